// File: rtl/arp_reply_engine.sv
// ARP responder: validates requests against NUM_IP local aliases, answers with a 7-word reply,
// and sends gratuitous ARP on request. Define ARP_STATS_EN to build the saturating statistics counters.
module arp_reply_engine #(
  parameter int NUM_IP = 4,
  parameter int CNT_W  = 16,
  localparam int IDX_W = (NUM_IP > 1) ? $clog2(NUM_IP) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          i_arp_data,
  input  logic                 i_arp_valid,
  input  logic                 i_arp_last,
  output logic                 i_arp_ready,
  output logic [31:0]          o_tx_data,
  output logic                 o_tx_valid,
  output logic                 o_tx_last,
  input  logic                 o_tx_ready,
  input  logic [47:0]          i_local_mac,
  input  logic [NUM_IP*32-1:0] i_local_ip,
  input  logic [NUM_IP-1:0]    i_ip_valid,
  input  logic                 i_arp_enable,
  input  logic                 i_garp_req,
  input  logic [IDX_W-1:0]     i_garp_idx,
  output logic [IDX_W-1:0]     o_match_idx,
  output logic [CNT_W-1:0]     o_cnt_rx,
  output logic [CNT_W-1:0]     o_cnt_tx,
  output logic [CNT_W-1:0]     o_cnt_drop
);

  typedef enum logic [2:0] {S_IDLE, S_RX, S_DRAIN, S_CHECK, S_TX} state_t;

  state_t           state_q, state_d;
  logic [2:0]       wcnt_q;
  logic [31:0]      rx_w0_q, rx_w1_q, rx_spa_q, rx_tpa_q;
  logic [47:0]      rx_sha_q;
  logic [15:0]      tx_oper_q;
  logic [47:0]      tx_sha_q, tx_tha_q;
  logic [31:0]      tx_spa_q, tx_tpa_q;
  logic             garp_pend_q;
  logic [IDX_W-1:0] garp_idx_q, match_idx_q;

  logic             in_hs, out_hs, match_found, reply_ok, garp_ok;
  logic [IDX_W-1:0] match_sel;
  logic [31:0]      garp_ip, match_ip;

  assign in_hs    = i_arp_valid && i_arp_ready;
  assign out_hs   = o_tx_valid && o_tx_ready;
  assign garp_ok  = (int'(garp_idx_q) < NUM_IP) && i_ip_valid[garp_idx_q];
  assign garp_ip  = i_local_ip[32*garp_idx_q +: 32];
  assign match_ip = i_local_ip[32*match_sel +: 32];
  assign reply_ok = i_arp_enable && (rx_w0_q == 32'h0001_0800) &&
                    (rx_w1_q == 32'h0604_0001) && match_found;

  // Scan from the top so the lowest matching alias index is the one that sticks.
  always_comb begin
    match_found = 1'b0;
    match_sel   = '0;
    for (int k = NUM_IP - 1; k >= 0; k--) begin
      if (i_ip_valid[k] && (i_local_ip[32*k +: 32] == rx_tpa_q)) begin
        match_found = 1'b1;
        match_sel   = IDX_W'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (garp_pend_q)      state_d = garp_ok ? S_TX : S_IDLE;
        else if (i_arp_valid) state_d = S_RX;
      end
      S_RX: begin
        if (in_hs) begin
          if (wcnt_q == 3'd6) state_d = i_arp_last ? S_CHECK : S_DRAIN;
          else if (i_arp_last) state_d = S_IDLE;
        end
      end
      S_DRAIN: if (in_hs && i_arp_last) state_d = S_CHECK;
      S_CHECK: state_d = reply_ok ? S_TX : S_IDLE;
      S_TX:    if (out_hs && (wcnt_q == 3'd6)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    i_arp_ready = 1'b0;
    o_tx_valid  = 1'b0;
    o_tx_last   = 1'b0;
    o_tx_data   = '0;
    case (state_q)
      S_RX, S_DRAIN: i_arp_ready = 1'b1;
      S_TX: begin
        o_tx_valid = 1'b1;
        o_tx_last  = (wcnt_q == 3'd6);
        case (wcnt_q)
          3'd0:    o_tx_data = 32'h0001_0800;
          3'd1:    o_tx_data = {16'h0604, tx_oper_q};
          3'd2:    o_tx_data = tx_sha_q[47:16];
          3'd3:    o_tx_data = {tx_sha_q[15:0], tx_spa_q[31:16]};
          3'd4:    o_tx_data = {tx_spa_q[15:0], tx_tha_q[47:32]};
          3'd5:    o_tx_data = tx_tha_q[31:0];
          default: o_tx_data = tx_tpa_q;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q      <= '0;
      rx_w0_q     <= '0;
      rx_w1_q     <= '0;
      rx_sha_q    <= '0;
      rx_spa_q    <= '0;
      rx_tpa_q    <= '0;
      tx_oper_q   <= '0;
      tx_sha_q    <= '0;
      tx_spa_q    <= '0;
      tx_tha_q    <= '0;
      tx_tpa_q    <= '0;
      match_idx_q <= '0;
    end else begin
      case (state_q)
        S_RX: begin
          if (in_hs) begin
            wcnt_q <= (wcnt_q == 3'd6) ? 3'd0 : wcnt_q + 3'd1;
            case (wcnt_q)
              3'd0: rx_w0_q <= i_arp_data;
              3'd1: rx_w1_q <= i_arp_data;
              3'd2: rx_sha_q[47:16] <= i_arp_data;
              3'd3: begin
                rx_sha_q[15:0]  <= i_arp_data[31:16];
                rx_spa_q[31:16] <= i_arp_data[15:0];
              end
              3'd4: rx_spa_q[15:0] <= i_arp_data[31:16];
              3'd6: rx_tpa_q <= i_arp_data;
              default: ;
            endcase
          end
        end
        S_TX: if (out_hs) wcnt_q <= (wcnt_q == 3'd6) ? 3'd0 : wcnt_q + 3'd1;
        default: wcnt_q <= '0;
      endcase

      // Frame contents are frozen on entry to TX so config changes cannot corrupt a frame in flight.
      if ((state_q == S_IDLE) && garp_pend_q && garp_ok) begin
        tx_oper_q <= 16'd1;
        tx_sha_q  <= i_local_mac;
        tx_spa_q  <= garp_ip;
        tx_tha_q  <= '0;
        tx_tpa_q  <= garp_ip;
      end else if ((state_q == S_CHECK) && reply_ok) begin
        tx_oper_q   <= 16'd2;
        tx_sha_q    <= i_local_mac;
        tx_spa_q    <= match_ip;
        tx_tha_q    <= rx_sha_q;
        tx_tpa_q    <= rx_spa_q;
        match_idx_q <= match_sel;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      garp_pend_q <= 1'b0;
      garp_idx_q  <= '0;
    end else if (i_garp_req) begin
      garp_pend_q <= 1'b1;
      garp_idx_q  <= i_garp_idx;
    end else if (state_q == S_IDLE) begin
      garp_pend_q <= 1'b0;
    end
  end

  assign o_match_idx = match_idx_q;

`ifdef ARP_STATS_EN
  logic             runt_evt, check_evt, tx_evt;
  logic [CNT_W-1:0] cnt_rx_q, cnt_tx_q, cnt_drop_q;

  assign runt_evt  = (state_q == S_RX) && in_hs && i_arp_last && (wcnt_q != 3'd6);
  assign check_evt = (state_q == S_CHECK);
  assign tx_evt    = out_hs && (wcnt_q == 3'd6);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_rx_q   <= '0;
      cnt_tx_q   <= '0;
      cnt_drop_q <= '0;
    end else begin
      if ((runt_evt || check_evt) && !(&cnt_rx_q)) cnt_rx_q <= cnt_rx_q + 1'b1;
      if (tx_evt && !(&cnt_tx_q)) cnt_tx_q <= cnt_tx_q + 1'b1;
      if ((runt_evt || (check_evt && !reply_ok)) && !(&cnt_drop_q)) cnt_drop_q <= cnt_drop_q + 1'b1;
    end
  end

  assign o_cnt_rx   = cnt_rx_q;
  assign o_cnt_tx   = cnt_tx_q;
  assign o_cnt_drop = cnt_drop_q;
`else
  assign o_cnt_rx   = '0;
  assign o_cnt_tx   = '0;
  assign o_cnt_drop = '0;
`endif

endmodule

// File: tb/tb_arp_reply_engine.sv
// Bench for arp_reply_engine: frame-level model (expected-reply queue + counters) checked on every
// output handshake, plus literal expectations for the reply and gratuitous ARP frames.
module tb_arp_reply_engine;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  i_arp_data = '0;
  logic         i_arp_valid = 1'b0, i_arp_last = 1'b0;
  logic         i_arp_ready;
  logic [31:0]  o_tx_data;
  logic         o_tx_valid, o_tx_last;
  logic         o_tx_ready = 1'b1;
  logic [47:0]  mac = 48'h02AA_BBCC_DDEE;
  logic [31:0]  alias_ip [4];
  logic [127:0] i_local_ip;
  logic [3:0]   i_ip_valid = 4'hF;
  logic         i_arp_enable = 1'b1;
  logic         i_garp_req = 1'b0;
  logic [1:0]   i_garp_idx = '0;
  logic [1:0]   o_match_idx;
  logic [15:0]  o_cnt_rx, o_cnt_tx, o_cnt_drop;

  assign i_local_ip = {alias_ip[3], alias_ip[2], alias_ip[1], alias_ip[0]};

  arp_reply_engine #(.NUM_IP(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_arp_data(i_arp_data), .i_arp_valid(i_arp_valid), .i_arp_last(i_arp_last), .i_arp_ready(i_arp_ready),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .o_tx_last(o_tx_last), .o_tx_ready(o_tx_ready),
    .i_local_mac(mac), .i_local_ip(i_local_ip), .i_ip_valid(i_ip_valid), .i_arp_enable(i_arp_enable),
    .i_garp_req(i_garp_req), .i_garp_idx(i_garp_idx), .o_match_idx(o_match_idx),
    .o_cnt_rx(o_cnt_rx), .o_cnt_tx(o_cnt_tx), .o_cnt_drop(o_cnt_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0][31:0] w;
    int               idx;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] fr [12];
  logic [31:0] got [7];
  logic [31:0] lit_reply [7] = '{32'h00010800, 32'h06040002, 32'h02AABBCC, 32'hDDEEC0A8,
                                 32'h010A0011, 32'h22334455, 32'hC0A80101};
  logic [31:0] lit_garp  [7] = '{32'h00010800, 32'h06040001, 32'h02AABBCC, 32'hDDEE0A00,
                                 32'h00010000, 32'h00000000, 32'h0A000001};
  int          n_checks = 0, n_err = 0, n_beats = 0, n_frames = 0;
  int          m_rx = 0, m_tx = 0, m_drop = 0;
  logic        stall_mode = 1'b0;
  logic [3:0]  pat = 4'b1001;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t pack(input logic [15:0] oper, input logic [47:0] sha, input logic [31:0] spa,
                                input logic [47:0] tha, input logic [31:0] tpa, input int idx);
    logic [223:0] p;
    exp_t e;
    p = {16'h0001, 16'h0800, 8'd6, 8'd4, oper, sha, spa, tha, tpa};
    for (int i = 0; i < 7; i++) e.w[i] = p[223-32*i -: 32];
    e.idx = idx;
    return e;
  endfunction

  function automatic void build_req(input logic [15:0] oper, input logic [47:0] sha,
                                    input logic [31:0] spa, input logic [31:0] tpa);
    logic [223:0] p;
    p = {16'h0001, 16'h0800, 8'd6, 8'd4, oper, sha, spa, 48'h0, tpa};
    for (int i = 0; i < 7; i++) fr[i] = p[223-32*i -: 32];
    for (int i = 7; i < 12; i++) fr[i] = 32'hDEAD0000 | i;
  endfunction

  // Decides from the whole captured frame what the responder must do with it.
  function automatic void model_frame(input int n);
    logic [223:0] p;
    int hit;
    m_rx++;
    if (n < 7) begin
      m_drop++;
      return;
    end
    for (int i = 0; i < 7; i++) p[223-32*i -: 32] = fr[i];
    hit = -1;
    for (int k = 3; k >= 0; k--) if (i_ip_valid[k] && alias_ip[k] == p[31:0]) hit = k;
    if (!i_arp_enable || p[223:208] != 16'h0001 || p[207:192] != 16'h0800 || p[191:184] != 8'd6 ||
        p[183:176] != 8'd4 || p[175:160] != 16'd1 || hit < 0) begin
      m_drop++;
      return;
    end
    exp_q.push_back(pack(16'd2, mac, alias_ip[hit], p[159:112], p[111:80], hit));
    m_tx++;
  endfunction

  function automatic void model_garp(input int idx);
    if (!i_ip_valid[idx]) return;
    exp_q.push_back(pack(16'd1, mac, alias_ip[idx], 48'h0, alias_ip[idx], -1));
    m_tx++;
  endfunction

  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) begin
      int t;
      i_arp_data  = fr[i];
      i_arp_valid = 1'b1;
      i_arp_last  = (i == n - 1);
      t = 0;
      forever begin
        @(negedge clk);
        if (i_arp_ready) break;
        t++;
        if (t > 200) begin
          chk("input ready timeout", i_arp_ready, 1'b1);
          break;
        end
      end
      @(posedge clk);
      #1;
    end
    i_arp_valid = 1'b0;
    i_arp_last  = 1'b0;
    i_arp_data  = '0;
  endtask

  task automatic quiet(input string name, input int cyc);
    int seen = 0;
    repeat (cyc) begin
      @(negedge clk);
      if (o_tx_valid) seen++;
    end
    chk(name, seen, 0);
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk({name, " drained"}, (exp_q.size() == 0), 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int t = 0;
    while (!o_tx_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({name, " tx start"}, o_tx_valid, 1'b1);
  endtask

  // Called right after the last input beat's handshake: one CHECK cycle, then beat 0 is valid.
  task automatic check_latency(input string name);
    @(negedge clk);
    chk({name, " latency cyc1"}, o_tx_valid, 1'b0);
    @(negedge clk);
    chk({name, " latency cyc2"}, o_tx_valid, 1'b1);
  endtask

  task automatic check_cnt(input string name);
`ifdef ARP_STATS_EN
    chk({name, " cnt_rx"}, o_cnt_rx, m_rx);
    chk({name, " cnt_tx"}, o_cnt_tx, m_tx);
    chk({name, " cnt_drop"}, o_cnt_drop, m_drop);
`else
    chk({name, " cnt_rx"}, o_cnt_rx, 0);
    chk({name, " cnt_tx"}, o_cnt_tx, 0);
    chk({name, " cnt_drop"}, o_cnt_drop, 0);
`endif
  endtask

  initial begin
    int pk = 0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_mode) begin
        o_tx_ready = pat[pk];
        pk = (pk + 1) % 4;
      end else begin
        o_tx_ready = 1'b1;
      end
    end
  end

  // Output compare: every handshake against the head of the expected queue, plus hold-while-stalled.
  initial begin
    int beat = 0;
    logic stalled = 1'b0;
    logic [31:0] held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        beat = 0;
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall hold valid", o_tx_valid, 1'b1);
          chk("stall hold data", o_tx_data, held);
        end
        if (o_tx_valid && exp_q.size() == 0) begin
          chk("unexpected tx valid", o_tx_valid, 1'b0);
        end else if (o_tx_valid && o_tx_ready) begin
          chk($sformatf("beat%0d data", beat), o_tx_data, exp_q[0].w[beat]);
          chk($sformatf("beat%0d last", beat), o_tx_last, (beat == 6));
          if (exp_q[0].idx >= 0) chk("match_idx", o_match_idx, exp_q[0].idx);
          got[beat] = o_tx_data;
          n_beats++;
          if (beat == 6) begin
            n_frames++;
            $display("frame %0d sent: oper word %08h tpa %08h", n_frames, exp_q[0].w[1], exp_q[0].w[6]);
            void'(exp_q.pop_front());
            beat = 0;
          end else begin
            beat++;
          end
        end
        stalled = o_tx_valid && !o_tx_ready;
        held = o_tx_data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    alias_ip[0] = 32'hC0A80001;
    alias_ip[1] = 32'h0A000001;
    alias_ip[2] = 32'hC0A8010A;
    alias_ip[3] = 32'hC0A80203;

    repeat (3) @(negedge clk);
    chk("reset tx_valid", o_tx_valid, 1'b0);
    chk("reset arp_ready", i_arp_ready, 1'b0);
    chk("reset tx_data", o_tx_data, 32'h0);
    chk("reset match_idx", o_match_idx, 2'd0);
    check_cnt("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: valid request to alias 2
    build_req(16'd1, 48'h0011_2233_4455, 32'hC0A80101, 32'hC0A8010A);
    send_frame(7);
    model_frame(7);
    for (int i = 0; i < 7; i++) chk($sformatf("model reply w%0d", i), exp_q[exp_q.size()-1].w[i], lit_reply[i]);
    check_latency("t1");
    wait_drain("t1");
    for (int i = 0; i < 7; i++) chk($sformatf("t1 reply w%0d", i), got[i], lit_reply[i]);
    chk("t1 match_idx", o_match_idx, 2'd2);
    check_cnt("t1");

    // 2: unknown TPA, reply opcode, disabled alias
    build_req(16'd1, 48'h0011_2233_4455, 32'hC0A80101, 32'hC0A80199);
    send_frame(7); model_frame(7); quiet("t2a no output", 12); check_cnt("t2a");
    build_req(16'd2, 48'h0011_2233_4455, 32'hC0A80101, 32'hC0A8010A);
    send_frame(7); model_frame(7); quiet("t2b no output", 12); check_cnt("t2b");
    i_ip_valid = 4'b1011;
    build_req(16'd1, 48'h0011_2233_4455, 32'hC0A80101, 32'hC0A8010A);
    send_frame(7); model_frame(7); quiet("t2c no output", 12); check_cnt("t2c");
    i_ip_valid = 4'hF;

    // 3: runt then valid frame to alias 0
    build_req(16'd1, 48'h0011_2233_4455, 32'hC0A80101, 32'hC0A8010A);
    send_frame(5); model_frame(5);
    build_req(16'd1, 48'hA1B2_C3D4_E5F6, 32'hC0A80177, 32'hC0A80001);
    send_frame(7); model_frame(7);
    wait_drain("t3");
    chk("t3 match_idx", o_match_idx, 2'd0);
    check_cnt("t3");

    // 4: padded 12-word frame to alias 3
    build_req(16'd1, 48'h0102_0304_0506, 32'h0A0B0C0D, 32'hC0A80203);
    send_frame(12); model_frame(12);
    check_latency("t4");
    wait_drain("t4");
    chk("t4 match_idx", o_match_idx, 2'd3);
    check_cnt("t4");

    // 5: downstream stalls, MAC changed mid-frame
    stall_mode = 1'b1;
    b0 = n_beats;
    build_req(16'd1, 48'h0011_2233_4455, 32'hC0A80101, 32'hC0A8010A);
    send_frame(7); model_frame(7);
    wait_valid("t5");
    mac = 48'h0;
    wait_drain("t5");
    chk("t5 beats delivered", n_beats - b0, 7);
    mac = 48'h02AA_BBCC_DDEE;
    stall_mode = 1'b0;
    check_cnt("t5");

    // enable drops mid-RX: frame consumed then dropped
    build_req(16'd1, 48'h0011_2233_4455, 32'hC0A80101, 32'hC0A8010A);
    fork
      send_frame(7);
      begin
        repeat (3) @(posedge clk);
        #2 i_arp_enable = 1'b0;
      end
    join
    model_frame(7);
    quiet("en-off no output", 12);
    i_arp_enable = 1'b1;
    check_cnt("en-off");

    // 6a: GARP requested during RX goes out after the reply
    build_req(16'd1, 48'h0011_2233_4455, 32'hC0A80101, 32'hC0A8010A);
    fork
      send_frame(7);
      begin
        repeat (2) @(posedge clk);
        #1 i_garp_req = 1'b1; i_garp_idx = 2'd1;
        @(posedge clk);
        #1 i_garp_req = 1'b0;
      end
    join
    model_frame(7);
    model_garp(1);
    wait_drain("t6a");
    for (int i = 0; i < 7; i++) chk($sformatf("t6a garp w%0d", i), got[i], lit_garp[i]);
    check_cnt("t6a");

    // 6b: pending GARP wins over a waiting request
    @(posedge clk);
    #1 i_garp_req = 1'b1; i_garp_idx = 2'd1;
    model_garp(1);
    @(posedge clk);
    #1 i_garp_req = 1'b0;
    build_req(16'd1, 48'h0011_2233_4455, 32'hC0A80101, 32'hC0A8010A);
    send_frame(7); model_frame(7);
    wait_drain("t6b");
    check_cnt("t6b");

    // 6c: asynchronous reset mid-TX
    build_req(16'd1, 48'h0011_2233_4455, 32'hC0A80101, 32'hC0A8010A);
    send_frame(7); model_frame(7);
    wait_valid("t6c");
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6c rst tx_valid", o_tx_valid, 1'b0);
    chk("t6c rst tx_last", o_tx_last, 1'b0);
    chk("t6c rst tx_data", o_tx_data, 32'h0);
    m_rx = 0; m_tx = 0; m_drop = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_cnt("t6c after rst");
    @(posedge clk);
    #1;
    build_req(16'd1, 48'h0011_2233_4455, 32'hC0A80101, 32'hC0A8010A);
    send_frame(7); model_frame(7);
    wait_drain("t6c recover");
    check_cnt("t6c recover");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
